// File: rtl/multi_tick_gen.sv
`default_nettype none
// ============================================================================
//  Module      : multi_tick_gen
//  Description : Multi-channel programmable tick generator. Each channel emits
//                a 1-cycle tick every `limit` clocks (periodic) or once per
//                start (one-shot), plus a mid-period tick for mid-bit sampling.
//  Revision    : 1.0 - initial release
// ============================================================================
module multi_tick_gen #(
    parameter int NUM_CH = 4,
    parameter int WIDTH  = 16
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    sync_clear,
    input  logic [NUM_CH-1:0]       enable,
    input  logic [NUM_CH-1:0]       oneshot,
    input  logic [NUM_CH-1:0]       start,
    input  logic [NUM_CH*WIDTH-1:0] limit,
    output logic [NUM_CH-1:0]       tick,
    output logic [NUM_CH-1:0]       mid_tick,
    output logic [NUM_CH-1:0]       busy,
    output logic [NUM_CH*WIDTH-1:0] count
);

    localparam logic [WIDTH-1:0] c_zero = '0;
    localparam logic [WIDTH-1:0] c_one  = WIDTH'(1);
    localparam logic [WIDTH-1:0] c_two  = WIDTH'(2);

    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
        logic [WIDTH-1:0] w_limit;
        logic [WIDTH-1:0] w_limit_m1;
        logic [WIDTH-1:0] w_half_m1;
        logic [WIDTH-1:0] r_count;
        logic             r_tick;
        logic             r_mid;
        logic             r_armed;
        logic             w_limit_nz;
        logic             w_active;
        logic             w_wrap;
        logic             w_mid_hit;

        assign w_limit    = limit[gi*WIDTH +: WIDTH];
        assign w_limit_nz = |w_limit;
        assign w_limit_m1 = w_limit - c_one;
        assign w_half_m1  = (w_limit >> 1) - c_one;

        // One-shot channels only count while armed; periodic ones whenever enabled.
        assign w_active  = enable[gi] & w_limit_nz & (~oneshot[gi] | r_armed);
        // Greater-or-equal so a shrunken limit wraps immediately instead of running to 2^WIDTH.
        assign w_wrap    = (r_count >= w_limit_m1);
        assign w_mid_hit = (w_limit >= c_two) && (r_count == w_half_m1);

        always_ff @(posedge clock or posedge reset) begin
            if (reset) begin
                r_count <= c_zero;
                r_tick  <= 1'b0;
                r_mid   <= 1'b0;
                r_armed <= 1'b0;
            end else if (sync_clear) begin
                r_count <= c_zero;
                r_tick  <= 1'b0;
                r_mid   <= 1'b0;
                r_armed <= 1'b0;
            end else if (start[gi]) begin
                r_count <= c_zero;
                r_tick  <= 1'b0;
                r_mid   <= 1'b0;
                if (oneshot[gi]) begin
                    r_armed <= 1'b1;
                end
            end else if (!w_limit_nz) begin
                r_count <= c_zero;
                r_tick  <= 1'b0;
                r_mid   <= 1'b0;
                r_armed <= 1'b0;
            end else if (!w_active) begin
                r_tick  <= 1'b0;
                r_mid   <= 1'b0;
            end else begin
                r_mid <= w_mid_hit;
                if (w_wrap) begin
                    r_count <= c_zero;
                    r_tick  <= 1'b1;
                    if (oneshot[gi]) begin
                        r_armed <= 1'b0;
                    end
                end else begin
                    r_count <= r_count + c_one;
                    r_tick  <= 1'b0;
                end
            end
        end

        assign tick[gi]                  = r_tick;
        assign mid_tick[gi]              = r_mid;
        assign count[gi*WIDTH +: WIDTH]  = r_count;
        // busy reads low while either clear is asserted, matching the cleared state.
        assign busy[gi] = ~reset & ~sync_clear & w_limit_nz &
                          (oneshot[gi] ? r_armed : enable[gi]);
    end

endmodule
`default_nettype wire
